// File: rtl/tmds_link_if.sv
// Pixel-side bundle of the TMDS link sequencer: raw video/sync in, serializer words and status out.
interface tmds_link_if;
    logic       enable;
    logic       de_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] vid_one_in;
    logic [9:0] vid_two_in;
    logic [9:0] vid_three_in;
    logic       ser_rst;
    logic [9:0] tmds_one;
    logic [9:0] tmds_two;
    logic [9:0] tmds_three;
    logic       link_up;

    modport master (
        output enable, de_in, hsync_in, vsync_in, vid_one_in, vid_two_in, vid_three_in,
        input  ser_rst, tmds_one, tmds_two, tmds_three, link_up
    );

    modport slave (
        input  enable, de_in, hsync_in, vsync_in, vid_one_in, vid_two_in, vid_three_in,
        output ser_rst, tmds_one, tmds_two, tmds_three, link_up
    );
endinterface

// File: rtl/tmds_link_seq.sv
// TMDS link bring-up sequencer: serializer reset, control-token settle, then video with
// preamble/guard-band insertion driven by a 10-cycle look-ahead on de_in.
module tmds_link_seq #(
    parameter int SER_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    tmds_link_if.slave link
);
    localparam logic [9:0] TOK00   = 10'b1101010100;
    localparam logic [9:0] TOK01   = 10'b0010101011;
    localparam logic [9:0] TOK10   = 10'b0101010100;
    localparam logic [9:0] TOK11   = 10'b1010101011;
    localparam logic [9:0] GB_EVEN = 10'b1011001100;
    localparam logic [9:0] GB_ODD  = 10'b0100110011;

    localparam int DLY     = 10;
    localparam int DW      = 33;
    localparam int CNT_MAX = (SER_RST_CYCLES > SETTLE_CYCLES) ? SER_RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SER_LAST    = CNT_W'(SER_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_DONE = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SERRST, SETTLE, RUN} state_t;
    typedef enum logic [2:0] {SEL_TOK00, SEL_BLANK, SEL_PRE, SEL_GUARD, SEL_VID} sel_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return TOK00;
            2'b01:   return TOK01;
            2'b10:   return TOK10;
            default: return TOK11;
        endcase
    endfunction

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       phase_cnt_reg, phase_cnt_next;
    logic                   pre_active_reg, pre_active_next;
    logic [3:0]             pre_k_reg, pre_k_next;
    logic                   de_prev_reg, vs_prev_reg;
    logic [DLY-1:0][DW-1:0] dly_reg;
    logic [2:0][9:0]        lane_reg, lane_next;
    logic                   ser_rst_reg, link_up_reg;

    logic                   de_d, hs_d, vs_d;
    logic [2:0][9:0]        vid_d;
    logic                   de_rise, vs_rise, pre_start, pre_run;
    logic [3:0]             k_eff;
    logic [9:0]             sync_tok;
    sel_t                   sel;

    // Stage 0 takes the raw inputs; the last stage feeds the output mux, so with the output
    // register the pipeline is 11 cycles deep and the raw de_in edge is a 10-cycle look-ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_reg <= '0;
        end else begin
            dly_reg <= {dly_reg[DLY-2:0],
                        {link.de_in, link.hsync_in, link.vsync_in,
                         link.vid_three_in, link.vid_two_in, link.vid_one_in}};
        end
    end

    assign de_d     = dly_reg[DLY-1][32];
    assign hs_d     = dly_reg[DLY-1][31];
    assign vs_d     = dly_reg[DLY-1][30];
    assign vid_d    = dly_reg[DLY-1][29:0];
    assign sync_tok = ctrl_token({vs_d, hs_d});
    assign de_rise  = link.de_in & ~de_prev_reg;
    assign vs_rise  = link.vsync_in & ~vs_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            phase_cnt_reg  <= '0;
            pre_active_reg <= 1'b0;
            pre_k_reg      <= '0;
            de_prev_reg    <= 1'b0;
            vs_prev_reg    <= 1'b0;
            lane_reg       <= {3{TOK00}};
            ser_rst_reg    <= 1'b1;
            link_up_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_cnt_reg  <= phase_cnt_next;
            pre_active_reg <= pre_active_next;
            pre_k_reg      <= pre_k_next;
            de_prev_reg    <= link.de_in;
            vs_prev_reg    <= link.vsync_in;
            lane_reg       <= lane_next;
            ser_rst_reg    <= (state_next == IDLE) || (state_next == SERRST);
            link_up_reg    <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        case (state_reg)
            IDLE: begin
                phase_cnt_next = '0;
                if (link.enable) state_next = SERRST;
            end
            SERRST: begin
                if (phase_cnt_reg == SER_LAST) begin
                    state_next     = SETTLE;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + CNT_W'(1);
                end
            end
            SETTLE: begin
                // Counter saturates at the settle length; the vsync edge is only honoured after.
                if (phase_cnt_reg == SETTLE_DONE) begin
                    if (vs_rise) state_next = RUN;
                end else begin
                    phase_cnt_next = phase_cnt_reg + CNT_W'(1);
                end
            end
            default: phase_cnt_next = '0;
        endcase
        if (!link.enable) begin
            state_next     = IDLE;
            phase_cnt_next = '0;
        end

        // A new line is announced 10 cycles ahead; k=0 is used on the edge cycle itself.
        pre_start       = (state_reg == RUN) && (state_next == RUN) && de_rise && !pre_active_reg;
        pre_run         = pre_active_reg || pre_start;
        k_eff           = pre_start ? 4'd0 : pre_k_reg;
        pre_active_next = 1'b0;
        pre_k_next      = pre_k_reg;
        if ((state_next == RUN) && pre_run && (k_eff != 4'd9)) begin
            pre_active_next = 1'b1;
            pre_k_next      = k_eff + 4'd1;
        end

        sel = SEL_TOK00;
        case (state_next)
            SETTLE: sel = SEL_BLANK;
            RUN: begin
                if (de_d)                sel = SEL_VID;
                else if (!pre_run)       sel = SEL_BLANK;
                else if (k_eff >= 4'd8)  sel = SEL_GUARD;
                else                     sel = SEL_PRE;
            end
            default: sel = SEL_TOK00;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            localparam logic [9:0] PRE_TOK = (gi == 1) ? TOK01 : TOK00;
            localparam logic [9:0] GUARD   = (gi == 1) ? GB_ODD : GB_EVEN;
            logic [9:0] ctrl_word;
            logic [9:0] word;

            assign ctrl_word = (gi == 0) ? sync_tok : TOK00;

            always_comb begin
                word = TOK00;
                case (sel)
                    SEL_BLANK: word = ctrl_word;
                    SEL_PRE:   word = (gi == 0) ? sync_tok : PRE_TOK;
                    SEL_GUARD: word = GUARD;
                    SEL_VID:   word = vid_d[gi];
                    default:   word = TOK00;
                endcase
            end

            assign lane_next[gi] = word;
        end
    endgenerate

    assign link.ser_rst    = ser_rst_reg;
    assign link.link_up    = link_up_reg;
    assign link.tmds_one   = lane_reg[0];
    assign link.tmds_two   = lane_reg[1];
    assign link.tmds_three = lane_reg[2];
endmodule

// File: tb/tb_tmds_link_seq.sv
// Directed bench for tmds_link_seq: bring-up timing, blanking token table, preamble/guard
// insertion around lines, enable drop and reset mid-run.
module tb_tmds_link_seq;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] GB0   = 10'b1011001100;
    localparam logic [9:0] GB1   = 10'b0100110011;

    typedef struct {
        logic       vs;
        logic       hs;
        logic [9:0] lane0;
        string      name;
    } blank_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tmds_link_if link();

    tmds_link_seq #(.SER_RST_CYCLES(16), .SETTLE_CYCLES(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic check_lanes(input string name, input logic [9:0] e0, input logic [9:0] e1,
                               input logic [9:0] e2);
        checks++;
        if ({link.tmds_one, link.tmds_two, link.tmds_three} !== {e0, e1, e2}) begin
            failures++;
            $display("FAIL %s got=%b/%b/%b expected=%b/%b/%b", name,
                     link.tmds_one, link.tmds_two, link.tmds_three, e0, e1, e2);
        end else begin
            $display("ok   %s lanes=%b/%b/%b", name, e0, e1, e2);
        end
    endtask

    function automatic logic [9:0] vid_word(input int lane, input int c);
        return 10'((lane * 211 + c * 7 + 37) % 1024);
    endfunction

    // Line A at c=0..19, 4-cycle gap, line B at c=24..38, long blank, 3-cycle pulse at c=60..62.
    function automatic logic stream_de(input int c);
        return (c <= 19) || (c >= 24 && c <= 38) || (c >= 60 && c <= 62);
    endfunction

    // Expected output after the j-th stream tick (video always reflects input from j-11).
    task automatic exp_stream(input int j, output logic [9:0] e0, output logic [9:0] e1,
                              output logic [9:0] e2);
        if ((j >= 1 && j <= 8) || j == 31 || j == 32 || (j >= 61 && j <= 68)) begin
            e0 = TOK01; e1 = TOK01; e2 = TOK00;
        end else if (j == 9 || j == 10 || j == 33 || j == 34 || j == 69 || j == 70) begin
            e0 = GB0; e1 = GB1; e2 = GB0;
        end else if ((j >= 11 && j <= 30) || (j >= 35 && j <= 49) || (j >= 71 && j <= 73)) begin
            e0 = vid_word(0, j - 11); e1 = vid_word(1, j - 11); e2 = vid_word(2, j - 11);
        end else begin
            e0 = TOK01; e1 = TOK00; e2 = TOK00;
        end
    endtask

    task automatic bring_up(input string tag);
        int cnt;
        int bad;
        link.enable = 1'b1;
        tick();
        cnt = 0;
        while (link.ser_rst === 1'b1 && cnt < 200) begin
            if (cnt == 14) check_lanes({tag, "_serrst_tok00"}, TOK00, TOK00, TOK00);
            cnt++;
            tick();
        end
        check_int({tag, "_serrst_len"}, cnt, 16);
        bad = 0;
        for (int n = 0; n < 70; n++) begin
            link.de_in    = (n >= 2 && n <= 4);
            link.vsync_in = (n == 30 || n == 31);
            tick();
            if (link.link_up !== 1'b0) bad++;
            if (n >= 2 && n <= 25)
                check_lanes($sformatf("%s_settle_n%0d", tag, n), TOK01, TOK00, TOK00);
        end
        check_int({tag, "_settle_link_low"}, bad, 0);
        link.de_in    = 1'b0;
        link.vsync_in = 1'b1;
        tick();
        check_int({tag, "_link_up"}, int'(link.link_up), 1);
        check_int({tag, "_run_ser_rst"}, int'(link.ser_rst), 0);
        tick();
        link.vsync_in = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        blank_vec_t bt[4];
        logic [9:0] e0, e1, e2;

        bt[0] = '{vs: 1'b0, hs: 1'b0, lane0: TOK00, name: "blank_v0h0"};
        bt[1] = '{vs: 1'b1, hs: 1'b0, lane0: TOK10, name: "blank_v1h0"};
        bt[2] = '{vs: 1'b1, hs: 1'b1, lane0: TOK11, name: "blank_v1h1"};
        bt[3] = '{vs: 1'b0, hs: 1'b1, lane0: TOK01, name: "blank_v0h1"};

        rst               = 1'b1;
        link.enable       = 1'b0;
        link.de_in        = 1'b0;
        link.hsync_in     = 1'b1;
        link.vsync_in     = 1'b0;
        link.vid_one_in   = '0;
        link.vid_two_in   = '0;
        link.vid_three_in = '0;
        tick();
        link.enable = 1'b1;
        tick();
        check_int("reset_ser_rst", int'(link.ser_rst), 1);
        check_int("reset_link_up", int'(link.link_up), 0);
        check_lanes("reset_lanes", TOK00, TOK00, TOK00);
        rst         = 1'b0;
        link.enable = 1'b0;
        tick();

        bring_up("up1");

        foreach (bt[i]) begin
            link.vsync_in = bt[i].vs;
            link.hsync_in = bt[i].hs;
            repeat (12) tick();
            check_lanes(bt[i].name, bt[i].lane0, TOK00, TOK00);
        end

        for (int c = 0; c < 80; c++) begin
            link.de_in        = stream_de(c);
            link.vid_one_in   = vid_word(0, c);
            link.vid_two_in   = vid_word(1, c);
            link.vid_three_in = vid_word(2, c);
            tick();
            exp_stream(c + 1, e0, e1, e2);
            check_lanes($sformatf("stream_j%0d", c + 1), e0, e1, e2);
        end

        link.de_in = 1'b1;
        repeat (5) tick();
        link.enable = 1'b0;
        tick();
        check_int("drop_ser_rst", int'(link.ser_rst), 1);
        check_int("drop_link_up", int'(link.link_up), 0);
        check_lanes("drop_lanes", TOK00, TOK00, TOK00);
        link.de_in = 1'b0;
        tick();

        bring_up("up2");

        link.de_in = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_int("midrun_rst_ser_rst", int'(link.ser_rst), 1);
        check_int("midrun_rst_link_up", int'(link.link_up), 0);
        check_lanes("midrun_rst_lanes", TOK00, TOK00, TOK00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
